calc_core_param: RTL and testbench
==================================

// Module: calc_core_param
// PURPOSE
//   Parametrised successor to the fixed 16-bit calculator core. Consumes single-cycle
//   key events from the keypad interface and keeps a signed accumulator and an entry
//   register. Performs add, subtract and multiply, with saturation and sticky overflow.
//   Drives magnitude plus sign to the 8-digit display driver and the overflow and sign LEDs.
//   Multiply is a sequential shift-add, so the block reports busy.
// PARAMETERS
//   WIDTH  16  datapath width; signed range is +/-(2^(WIDTH-1)-1), symmetric
//   RADIX  16  digit entry base; only 10 or 16 are legal
// PORTS
//   clock    in   1      system clock (5 MHz in the board build)
//   resetn   in   1      asynchronous, active-low reset
//   newkey   in   1      one-cycle pulse; keycode is valid in that cycle
//   keycode  in   5      [4]=0: digit [3:0]; 10 add, 11 sub, 12 mul, 13 equals, 14 clear; others are ignored
//   value    out  WIDTH  magnitude of the displayed register
//   sign     out  1      1 = displayed register is negative
//   ovw      out  1      sticky overflow flag
//   busy     out  1      multiply in progress; keys are dropped while high
// BEHAVIOUR
//   - Reset (async, resetn=0): acc, entry, op, value, sign, ovw and busy all = 0; state = ENTRY_A.
//   - States: ENTRY_A, OP_PEND, ENTRY_B, MULT, RESULT.
//   - Each key is acted on in the newkey cycle. value, sign and ovw are registered and
//     change on the next clock edge, so latency is 1 cycle.
//   - Digit key d:
//       - If d >= RADIX the key is ignored.
//       - ENTRY_A/ENTRY_B: entry <= entry*RADIX + d. If the result exceeds 2^(WIDTH-1)-1,
//         the digit is ignored and entry is unchanged. ovw is not set.
//       - OP_PEND: entry <= d; go to ENTRY_B.
//       - RESULT: entry <= d; ovw <= 0; go to ENTRY_A.
//   - Operator key (add/sub/mul):
//       - ENTRY_A: acc <= entry.
//       - RESULT: acc is unchanged.
//       - In both cases op <= key and the state goes to OP_PEND.
//       - OP_PEND: op is replaced; nothing else changes.
//       - ENTRY_B: chained evaluation of acc op entry. The result goes to acc, the new op
//         is stored, and the state goes to OP_PEND once the evaluation completes.
//   - Equals key: in ENTRY_B, evaluate acc op entry and go to RESULT. In every other state
//     it is ignored.
//   - Clear key: same effect as reset, synchronous. It is accepted in every state except MULT.
//   - Entry sign: entry is always non-negative; negatives arise only from arithmetic.
//   - Add/sub: computed at WIDTH+1 bits. The result is written in the cycle after the key.
//   - Mul: enter MULT with busy=1. One partial product per cycle, magnitudes
//     only, 2*WIDTH-bit product, sign = XOR of the operand signs.
//       - Completion takes exactly WIDTH cycles after entry to MULT; busy falls with the write.
//       - Every newkey while busy=1 is dropped, including clear.
//   - Saturation: if a result is outside +/-(2^(WIDTH-1)-1), acc is clamped to that bound
//     with the result's sign and ovw <= 1.
//       - -2^(WIDTH-1) counts as overflow.
//       - ovw stays 1 until clear, reset, or a digit in RESULT.
//   - Display selection:
//       - ENTRY_A/ENTRY_B: value = entry, sign = 0.
//       - OP_PEND/RESULT: value = |acc|, sign = acc<0.
//       - MULT: value holds its last value.
//   - Zero result: sign = 0. -0 never appears.
//   - Reset during MULT: the multiply aborts at once and all outputs take their reset values.
//   - newkey held high for several cycles: each cycle counts as a separate key, because the
//     keypad guarantees single pulses.
// TESTING (WIDTH=16 unless stated)
//   1. RADIX=16; keys 1,2,add,3,equals -> value=0x0015, sign=0, ovw=0, state RESULT.
//   2. Keys 5,sub,9,equals -> value=0x0004, sign=1.
//      Then add,4,equals -> value=0, sign=0.
//   3. Keys 7,F,F,F,add,1,equals -> value=0x7FFF, ovw=1.
//      Then digit 2 -> value=0x0002, ovw=0.
//   4. Keys 3,mul,4,equals -> busy=1 for exactly 16 cycles, then value=0x000C.
//      A digit key pulsed mid-multiply is dropped; value stays 0x000C.
//   5. Keys 2,add,3,add -> value=5 while in OP_PEND.
//      Then 4,equals -> value=9.
//      Then 1,0,0,mul,1,0,0,equals -> value=0x7FFF, ovw=1.
//   6. RADIX=10, WIDTH=8: key A is ignored; keys 1,2,7 -> value=127; a further digit 0 is
//      ignored. Assert resetn mid-MULT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/calc_core_param.sv
// Parametrised keypad calculator core.
// Keeps a signed accumulator and a non-negative entry register, evaluates
// add/sub in one cycle and multiply as a WIDTH-cycle shift-add, saturates
// symmetrically to +/-(2^(WIDTH-1)-1) with a sticky overflow flag, and
// drives a registered magnitude/sign pair to the display.
// Keycode map: [4]=0 -> digit [3:0]; [4]=1 -> [3:0] 10 add, 11 sub,
// 12 mul, 13 equals, 14 clear; every other code is ignored.
// WIDTH must be at least 5; RADIX must be 10 or 16.
module calc_core_param #(
  parameter int WIDTH = 16,
  parameter int RADIX = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             newkey,
  input  logic [4:0]       keycode,
  output logic [WIDTH-1:0] value,
  output logic             sign,
  output logic             ovw,
  output logic             busy
);

  // Entry growth headroom: entry*16 + 15 never needs more than WIDTH+4 bits.
  localparam int EW = WIDTH + 5;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG   = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
  localparam logic [4:0]       RADIX_V   = 5'(RADIX);
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [2:0] {ENTRY_A, OP_PEND, ENTRY_B, MULT, RESULT} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t             state;
  op_t                op;
  op_t                key_code_op;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   entry;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      mul_cnt;
  logic               mul_sign;
  logic               mul_to_result;

  // Magnitude of a two's-complement value; acc never holds -2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  // ---------------------------------------------------------------------
  // Key decode
  // ---------------------------------------------------------------------
  logic key_digit;
  logic key_op;
  logic key_eq;
  logic key_clr;
  logic [WIDTH-1:0] digit_val;

  // Map operator keycodes onto the stored operation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    key_code_op = OP_NONE;
    case (keycode[3:0])
      4'd10:   key_code_op = OP_ADD;
      4'd11:   key_code_op = OP_SUB;
      4'd12:   key_code_op = OP_MUL;
      default: key_code_op = OP_NONE;
    endcase
  end

  assign key_digit = newkey && !keycode[4] && ({1'b0, keycode[3:0]} < RADIX_V);
  assign key_op    = newkey &&  keycode[4] && (key_code_op != OP_NONE);
  assign key_eq    = newkey &&  keycode[4] && (keycode[3:0] == 4'd13);
  assign key_clr   = newkey &&  keycode[4] && (keycode[3:0] == 4'd14);
  assign digit_val = {{(WIDTH-4){1'b0}}, keycode[3:0]};

  // Digit append; a digit that would push entry past MAX_POS is dropped.
  logic [EW-1:0] entry_ext;
  logic          digit_fits;
  assign entry_ext  = ({5'b0, entry} * EW'(RADIX)) + EW'(keycode[3:0]);
  assign digit_fits = entry_ext <= {5'b0, MAX_POS};

  // ---------------------------------------------------------------------
  // Add / subtract at WIDTH+1 bits with symmetric saturation
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   as_sum;
  logic             as_ovf;
  logic [WIDTH-1:0] as_res;
  assign as_sum = (op == OP_SUB) ? ({acc[WIDTH-1], acc} - {1'b0, entry})
                                 : ({acc[WIDTH-1], acc} + {1'b0, entry});
  // Out of WIDTH-bit range, or exactly -2^(WIDTH-1), which is outside the symmetric range.
  assign as_ovf = (as_sum[WIDTH] ^ as_sum[WIDTH-1]) ||
                  (as_sum == {2'b11, {(WIDTH-1){1'b0}}});
  assign as_res = as_ovf ? (as_sum[WIDTH] ? MAX_NEG : MAX_POS) : as_sum[WIDTH-1:0];

  // ---------------------------------------------------------------------
  // Shift-add multiply step and final saturation
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]   acc_mag;
  logic [2*WIDTH-1:0] mul_full;
  logic               mul_ovf;
  logic [WIDTH-1:0]   mul_mag;
  logic               mul_neg;
  logic [WIDTH-1:0]   mul_res;
  assign acc_mag  = mag_of(acc);
  assign mul_full = prod + (mplier[0] ? mcand : '0);
  assign mul_ovf  = mul_full > {{WIDTH{1'b0}}, MAX_POS};
  assign mul_mag  = mul_ovf ? MAX_POS : mul_full[WIDTH-1:0];
  // A zero product is always positive so -0 cannot appear.
  assign mul_neg  = mul_sign && (mul_mag != '0);
  assign mul_res  = mul_neg ? -mul_mag : mul_mag;

  // ---------------------------------------------------------------------
  // Control FSM with registered datapath and display outputs
  // ---------------------------------------------------------------------
  // Key handling, arithmetic write-back and display update on each clock.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      state         <= ENTRY_A;
      op            <= OP_NONE;
      acc           <= '0;
      entry         <= '0;
      value         <= '0;
      sign          <= 1'b0;
      ovw           <= 1'b0;
      busy          <= 1'b0;
      mcand         <= '0;
      prod          <= '0;
      mplier        <= '0;
      mul_cnt       <= '0;
      mul_sign      <= 1'b0;
      mul_to_result <= 1'b0;
    end else if (key_clr && (state != MULT)) begin
      state         <= ENTRY_A;
      op            <= OP_NONE;
      acc           <= '0;
      entry         <= '0;
      value         <= '0;
      sign          <= 1'b0;
      ovw           <= 1'b0;
      busy          <= 1'b0;
      mcand         <= '0;
      prod          <= '0;
      mplier        <= '0;
      mul_cnt       <= '0;
      mul_sign      <= 1'b0;
      mul_to_result <= 1'b0;
    end else begin
      case (state)
        ENTRY_A: begin
          if (key_digit) begin
            if (digit_fits) begin
              entry <= entry_ext[WIDTH-1:0];
              value <= entry_ext[WIDTH-1:0];
              sign  <= 1'b0;
            end
          end else if (key_op) begin
            acc   <= entry;
            op    <= key_code_op;
            value <= entry;
            sign  <= 1'b0;
            state <= OP_PEND;
          end
        end

        OP_PEND: begin
          if (key_digit) begin
            entry <= digit_val;
            value <= digit_val;
            sign  <= 1'b0;
            state <= ENTRY_B;
          end else if (key_op) begin
            op <= key_code_op;
          end
        end

        ENTRY_B: begin
          if (key_digit) begin
            if (digit_fits) begin
              entry <= entry_ext[WIDTH-1:0];
              value <= entry_ext[WIDTH-1:0];
              sign  <= 1'b0;
            end
          end else if (key_op || key_eq) begin
            if (key_op) op <= key_code_op;
            if (op == OP_MUL) begin
              // Display keeps showing the entry until the product is written.
              mcand         <= {{WIDTH{1'b0}}, acc_mag};
              mplier        <= entry;
              prod          <= '0;
              mul_cnt       <= '0;
              mul_sign      <= acc[WIDTH-1];
              mul_to_result <= key_eq;
              busy          <= 1'b1;
              state         <= MULT;
            end else begin
              acc   <= as_res;
              ovw   <= ovw | as_ovf;
              value <= mag_of(as_res);
              sign  <= as_res[WIDTH-1];
              state <= key_eq ? RESULT : OP_PEND;
            end
          end
        end

        MULT: begin
          // Keys are deliberately ignored here, clear included.
          if (mul_cnt == LAST_STEP) begin
            acc   <= mul_res;
            ovw   <= ovw | mul_ovf;
            value <= mul_mag;
            sign  <= mul_neg;
            busy  <= 1'b0;
            state <= mul_to_result ? RESULT : OP_PEND;
          end else begin
            prod    <= mul_full;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt + CW'(1);
          end
        end

        RESULT: begin
          if (key_digit) begin
            entry <= digit_val;
            value <= digit_val;
            sign  <= 1'b0;
            ovw   <= 1'b0;
            state <= ENTRY_A;
          end else if (key_op) begin
            op    <= key_code_op;
            state <= OP_PEND;
          end
        end

        default: state <= ENTRY_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_core_param.sv
// Directed bench for calc_core_param: a WIDTH=16/RADIX=16 instance for the
// arithmetic paths and a WIDTH=8/RADIX=10 instance for decimal entry and
// asynchronous reset during a multiply. Expected display states are queued
// when keys are driven and popped when the outputs are sampled.
module tb_calc_core_param;

  localparam logic [4:0] K_ADD = 5'h1A;
  localparam logic [4:0] K_SUB = 5'h1B;
  localparam logic [4:0] K_MUL = 5'h1C;
  localparam logic [4:0] K_EQ  = 5'h1D;
  localparam logic [4:0] K_CLR = 5'h1E;

  logic        clock;
  logic        resetn;
  logic        newkey;
  logic [4:0]  keycode;
  logic [15:0] value16;
  logic        sign16;
  logic        ovw16;
  logic        busy16;

  logic        resetn8;
  logic        newkey8;
  logic [4:0]  keycode8;
  logic [7:0]  value8;
  logic        sign8;
  logic        ovw8;
  logic        busy8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [15:0] value;
    logic        sign;
    logic        ovw;
  } exp_t;

  exp_t sb[$];

  calc_core_param #(.WIDTH(16), .RADIX(16)) dut16 (
    .clock   (clock),
    .resetn  (resetn),
    .newkey  (newkey),
    .keycode (keycode),
    .value   (value16),
    .sign    (sign16),
    .ovw     (ovw16),
    .busy    (busy16)
  );

  calc_core_param #(.WIDTH(8), .RADIX(10)) dut8 (
    .clock   (clock),
    .resetn  (resetn8),
    .newkey  (newkey8),
    .keycode (keycode8),
    .value   (value8),
    .sign    (sign8),
    .ovw     (ovw8),
    .busy    (busy8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] v, input logic s, input logic o);
    exp_t e;
    e.tag = tag; e.value = v; e.sign = s; e.ovw = o;
    sb.push_back(e);
  endtask

  task automatic compare16();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_value"}, {16'd0, value16}, {16'd0, e.value});
      check({e.tag, "_sign"},  {31'd0, sign16},  {31'd0, e.sign});
      check({e.tag, "_ovw"},   {31'd0, ovw16},   {31'd0, e.ovw});
    end
  endtask

  task automatic compare8();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_value"}, {24'd0, value8}, {16'd0, e.value});
      check({e.tag, "_sign"},  {31'd0, sign8},  {31'd0, e.sign});
      check({e.tag, "_ovw"},   {31'd0, ovw8},   {31'd0, e.ovw});
    end
  endtask

  // One-cycle key pulse; returns after the capturing edge has updated outputs.
  task automatic press(input logic [4:0] k);
    @(negedge clock);
    newkey  = 1'b1;
    keycode = k;
    @(negedge clock);
    newkey  = 1'b0;
  endtask

  task automatic press8(input logic [4:0] k);
    @(negedge clock);
    newkey8  = 1'b1;
    keycode8 = k;
    @(negedge clock);
    newkey8  = 1'b0;
  endtask

  task automatic wait_idle16(input string tag);
    int n;
    n = 0;
    while (busy16 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy16}, 32'd0);
  endtask

  initial begin
    int          cnt;
    logic [15:0] mid_val;

    resetn   = 1'b0;
    newkey   = 1'b0;
    keycode  = 5'd0;
    resetn8  = 1'b0;
    newkey8  = 1'b0;
    keycode8 = 5'd0;
    repeat (3) @(negedge clock);

    expect_out("reset16", 16'h0000, 1'b0, 1'b0);
    compare16();
    check("reset16_busy", {31'd0, busy16}, 32'd0);
    expect_out("reset8", 16'h0000, 1'b0, 1'b0);
    compare8();
    check("reset8_busy", {31'd0, busy8}, 32'd0);

    resetn  = 1'b1;
    resetn8 = 1'b1;
    @(negedge clock);

    // 1 2 + 3 = -> 0x15
    press(5'h01); press(5'h02); press(K_ADD); press(5'h03);
    expect_out("t1_entry_b", 16'h0003, 1'b0, 1'b0);
    compare16();
    press(K_EQ);
    expect_out("t1_sum", 16'h0015, 1'b0, 1'b0);
    compare16();
    press(K_EQ);
    expect_out("t1_eq_ignored", 16'h0015, 1'b0, 1'b0);
    compare16();
    press(K_CLR);
    expect_out("t1_clear", 16'h0000, 1'b0, 1'b0);
    compare16();

    // 5 - 9 = -> -4, then + 4 = -> 0 with positive sign
    press(5'h05); press(K_SUB); press(5'h09); press(K_EQ);
    expect_out("t2_neg", 16'h0004, 1'b1, 1'b0);
    compare16();
    press(K_ADD); press(5'h04); press(K_EQ);
    expect_out("t2_zero", 16'h0000, 1'b0, 1'b0);
    compare16();

    // -4 * 3 = -> -12 (sign carried through the multiplier)
    press(K_CLR); press(5'h05); press(K_SUB); press(5'h09); press(K_EQ);
    press(K_MUL); press(5'h03); press(K_EQ);
    wait_idle16("neg_mul");
    expect_out("neg_mul", 16'h000C, 1'b1, 1'b0);
    compare16();

    // 7FFF entry limit, positive saturation, digit in RESULT clears ovw
    press(K_CLR);
    press(5'h07); press(5'h0F); press(5'h0F); press(5'h0F);
    expect_out("t3_entry_max", 16'h7FFF, 1'b0, 1'b0);
    compare16();
    press(5'h00);
    expect_out("t3_digit_ignored", 16'h7FFF, 1'b0, 1'b0);
    compare16();
    press(K_ADD); press(5'h01); press(K_EQ);
    expect_out("t3_sat_pos", 16'h7FFF, 1'b0, 1'b1);
    compare16();
    press(5'h02);
    expect_out("t3_ovw_cleared", 16'h0002, 1'b0, 1'b0);
    compare16();

    // 1 - 7FFF = -7FFE, then - 2 hits -2^15, which saturates to -7FFF
    press(K_CLR); press(5'h01); press(K_SUB);
    press(5'h07); press(5'h0F); press(5'h0F); press(5'h0F); press(K_EQ);
    expect_out("neg_near_min", 16'h7FFE, 1'b1, 1'b0);
    compare16();
    press(K_SUB); press(5'h02); press(K_EQ);
    expect_out("sat_neg_min", 16'h7FFF, 1'b1, 1'b1);
    compare16();

    // 3 * 4 = : busy for exactly 16 cycles, a mid-multiply digit is dropped
    press(K_CLR); press(5'h03); press(K_MUL); press(5'h04); press(K_EQ);
    cnt     = 0;
    mid_val = 16'hFFFF;
    while (busy16 && cnt < 100) begin
      cnt++;
      if (cnt == 5) begin
        newkey  = 1'b1;
        keycode = 5'h07;
      end else begin
        newkey  = 1'b0;
      end
      if (cnt == 8) mid_val = value16;
      @(negedge clock);
    end
    newkey = 1'b0;
    check("t4_busy_cycles", cnt, 32'd16);
    check("t4_value_held", {16'd0, mid_val}, 32'h0000_0004);
    expect_out("t4_product", 16'h000C, 1'b0, 1'b0);
    compare16();
    press(K_ADD); press(5'h01); press(K_EQ);
    expect_out("t4_after_mul", 16'h000D, 1'b0, 1'b0);
    compare16();

    // Chained evaluation and multiply saturation
    press(K_CLR); press(5'h02); press(K_ADD); press(5'h03); press(K_ADD);
    expect_out("t5_chain", 16'h0005, 1'b0, 1'b0);
    compare16();
    press(5'h04); press(K_EQ);
    expect_out("t5_sum", 16'h0009, 1'b0, 1'b0);
    compare16();
    press(5'h01); press(5'h00); press(5'h00); press(K_MUL);
    press(5'h01); press(5'h00); press(5'h00); press(K_EQ);
    wait_idle16("t5_mul");
    expect_out("t5_mul_sat", 16'h7FFF, 1'b0, 1'b1);
    compare16();
    press(K_CLR);
    expect_out("t5_clear", 16'h0000, 1'b0, 1'b0);
    compare16();

    // WIDTH=8, RADIX=10: A ignored, entry capped at 127, async reset in MULT
    press8(5'h0A);
    expect_out("t6_key_a", 16'h0000, 1'b0, 1'b0);
    compare8();
    press8(5'h01); press8(5'h02); press8(5'h07);
    expect_out("t6_entry_127", 16'h007F, 1'b0, 1'b0);
    compare8();
    press8(5'h00);
    expect_out("t6_digit_ignored", 16'h007F, 1'b0, 1'b0);
    compare8();
    press8(K_MUL); press8(5'h02); press8(K_EQ);
    check("t6_busy", {31'd0, busy8}, 32'd1);
    expect_out("t6_mult_hold", 16'h0002, 1'b0, 1'b0);
    compare8();
    repeat (3) @(negedge clock);
    #2 resetn8 = 1'b0;
    #1;
    expect_out("t6_async_reset", 16'h0000, 1'b0, 1'b0);
    compare8();
    check("t6_reset_busy", {31'd0, busy8}, 32'd0);
    @(negedge clock);
    resetn8 = 1'b1;

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
